// File: rtl/hw2_func_lut_seq.sv
// hw2_func_lut_seq: programmable N-input LUT with a serially loaded shadow table, a valid/ready output register and a saturating count of delivered 1s.
module hw2_func_lut_seq #(
  parameter int N_IN = 4,
  parameter logic [2**N_IN-1:0] INIT_TABLE = 16'h3F75,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start_i,
  input  logic             cfg_valid_i,
  input  logic             cfg_bit_i,
  output logic             cfg_busy_o,
  output logic             cfg_done_o,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [N_IN-1:0]  in_vec_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_f_o,
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] true_cnt_o
);
  localparam int T = 2**N_IN;
  typedef enum logic [1:0] {IDLE, LOAD, SWAP} state_t;
  state_t state_q, state_d;
  logic [T-1:0] act_q, act_d, shd_q, shd_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic out_valid_q, out_valid_d, out_f_q, out_f_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic accept, deliver;
  always_comb begin
    state_d = state_q;
    act_d = act_q;
    shd_d = shd_q;
    idx_d = idx_q;
    case (state_q)
      IDLE: if (cfg_start_i) begin
        state_d = LOAD;
        idx_d = '0;
        shd_d = '0;
      end
      LOAD: if (cfg_start_i) begin
        idx_d = '0;
        shd_d = '0;
      end else if (cfg_valid_i) begin
        shd_d[idx_q] = cfg_bit_i;
        idx_d = idx_q + N_IN'(1);
        state_d = &idx_q ? SWAP : LOAD;
      end
      SWAP: begin
        act_d = shd_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign in_ready_o = !out_valid_q || out_ready_i;
  assign accept = in_valid_i && in_ready_o;
  assign deliver = out_valid_q && out_ready_i && out_f_q;
  // a vector accepted during SWAP still sees act_q, the old table
  always_comb begin
    out_f_d = accept ? act_q[in_vec_i] : out_f_q;
    out_valid_d = accept ? 1'b1 : (out_ready_i ? 1'b0 : out_valid_q);
    cnt_d = cnt_clr_i ? '0 : ((deliver && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      act_q <= INIT_TABLE;
      shd_q <= '0;
      idx_q <= '0;
      out_valid_q <= 1'b0;
      out_f_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      act_q <= act_d;
      shd_q <= shd_d;
      idx_q <= idx_d;
      out_valid_q <= out_valid_d;
      out_f_q <= out_f_d;
      cnt_q <= cnt_d;
    end
  end
  assign cfg_busy_o = state_q != IDLE;
  assign cfg_done_o = state_q == SWAP;
  assign out_valid_o = out_valid_q;
  assign out_f_o = out_f_q;
  assign true_cnt_o = cnt_q;
endmodule

// File: tb/tb_hw2_func_lut_seq.sv
// tb_hw2_func_lut_seq: directed test-plan scenarios plus random traffic, checked cycle by cycle against a behavioural model.
module tb_hw2_func_lut_seq;
  logic clk = 0, rst = 0;
  logic cfg_start = 0, cfg_valid = 0, cfg_bit = 0, in_valid = 0, out_ready = 0, cnt_clr = 0;
  logic [3:0] in_vec = 0;
  logic cfg_busy, cfg_done, in_ready, out_valid, out_f;
  logic [7:0] true_cnt;
  logic b2, d2, r2, v2, f2;
  logic [1:0] cnt2;
  int total = 0, bad = 0;
  logic [15:0] m_tab, m_sh;
  bit m_ov, m_f, m_ld, m_sw;
  int m_idx, m_c8, m_c2;
  always #5 clk = ~clk;
  hw2_func_lut_seq dut (
    .clk(clk), .rst(rst), .cfg_start_i(cfg_start), .cfg_valid_i(cfg_valid), .cfg_bit_i(cfg_bit),
    .cfg_busy_o(cfg_busy), .cfg_done_o(cfg_done), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_vec_i(in_vec), .out_valid_o(out_valid), .out_ready_i(out_ready), .out_f_o(out_f),
    .cnt_clr_i(cnt_clr), .true_cnt_o(true_cnt)
  );
  hw2_func_lut_seq #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .cfg_start_i(cfg_start), .cfg_valid_i(cfg_valid), .cfg_bit_i(cfg_bit),
    .cfg_busy_o(b2), .cfg_done_o(d2), .in_valid_i(in_valid), .in_ready_o(r2),
    .in_vec_i(in_vec), .out_valid_o(v2), .out_ready_i(out_ready), .out_f_o(f2),
    .cnt_clr_i(cnt_clr), .true_cnt_o(cnt2)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_outs();
    check("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    check("out_f", {31'd0, out_f}, {31'd0, m_f});
    check("cfg_busy", {31'd0, cfg_busy}, {31'd0, m_ld | m_sw});
    check("cfg_done", {31'd0, cfg_done}, {31'd0, m_sw});
    check("cnt8", {24'd0, true_cnt}, m_c8);
    check("cnt2", {30'd0, cnt2}, m_c2);
  endtask
  task automatic model_reset();
    m_tab = 16'h3F75; m_sh = 0; m_ov = 0; m_f = 0; m_ld = 0; m_sw = 0; m_idx = 0; m_c8 = 0; m_c2 = 0;
  endtask
  task automatic do_reset();
    {cfg_start, cfg_valid, cfg_bit, in_valid, out_ready, cnt_clr} = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    check_outs();
  endtask
  task automatic step(input logic cs, cv, cb, iv, input logic [3:0] v, input logic ordy, clr);
    bit acc, dlv;
    cfg_start = cs; cfg_valid = cv; cfg_bit = cb; in_valid = iv; in_vec = v; out_ready = ordy; cnt_clr = clr;
    #1;
    check("in_ready", {31'd0, in_ready}, {31'd0, !m_ov || ordy});
    acc = iv && (!m_ov || ordy);
    dlv = m_ov && ordy && m_f;
    m_c8 = clr ? 0 : (dlv && m_c8 < 255) ? m_c8 + 1 : m_c8;
    m_c2 = clr ? 0 : (dlv && m_c2 < 3) ? m_c2 + 1 : m_c2;
    if (acc) begin m_f = m_tab[v]; m_ov = 1; end
    else if (ordy) m_ov = 0;
    if (m_sw) begin m_tab = m_sh; m_sw = 0; end
    else if (m_ld) begin
      if (cs) begin m_idx = 0; m_sh = 0; end
      else if (cv) begin
        m_sh[m_idx] = cb;
        m_idx++;
        if (m_idx == 16) begin m_ld = 0; m_sw = 1; end
      end
    end else if (cs) begin m_ld = 1; m_idx = 0; m_sh = 0; end
    @(posedge clk); #1;
    check_outs();
  endtask
  task automatic load_bits(input logic [15:0] w, input int n, input logic iv, input logic [3:0] v);
    for (int i = 0; i < n; i++) step(0, 1, w[i], iv, v, 1, 0);
  endtask
  initial begin
    int dones;
    model_reset();
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 4'(i), 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    check("sweep_cnt", {24'd0, true_cnt}, 11);
    check("sweep_cnt2", {30'd0, cnt2}, 3);
    step(0, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 2, 0, 0);
    check("bp_hold", {30'd0, out_valid, out_f}, 32'h2);
    step(0, 0, 0, 1, 0, 1, 0);
    check("bp_new", {30'd0, out_valid, out_f}, 32'h3);
    step(0, 0, 0, 0, 0, 1, 0);
    dones = 0;
    step(1, 0, 0, 0, 0, 1, 0);
    load_bits(16'h8001, 16, 0, 0);
    check("reload_busy", {31'd0, cfg_busy}, 1);
    check("reload_done17", {31'd0, cfg_done}, 1);
    step(0, 0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 15, 1, 0);
    step(0, 0, 0, 1, 5, 1, 0);
    check("reload_f5", {31'd0, out_f}, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    load_bits(16'hFFFF, 7, 0, 0);
    step(1, 1, 1, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, i < 8, 0, 0, 1, 0);
      dones += cfg_done;
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 1, 0);
      dones += cfg_done;
    end
    check("restart_dones", dones, 1);
    check("restart_table", m_tab, 16'h00FF);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 4'(i), 1, 0);
    do_reset();
    step(1, 0, 0, 0, 0, 1, 0);
    load_bits(16'hFFFF, 16, 0, 0);
    step(0, 0, 0, 1, 3, 1, 0);
    check("swap_old", {31'd0, out_f}, 0);
    step(0, 0, 0, 1, 3, 1, 0);
    check("swap_new", {31'd0, out_f}, 1);
    do_reset();
    for (int i = 0; i < 6; i++) step(0, 0, 0, i < 5, 0, 1, 0);
    check("sat_cnt2", {30'd0, cnt2}, 3);
    step(0, 0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    check("clr_cnt2", {30'd0, cnt2}, 0);
    step(1, 0, 0, 1, 2, 1, 0);
    load_bits(16'h0000, 5, 1, 3);
    do_reset();
    check("rst_busy", {31'd0, cfg_busy}, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 4'(i), 1, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
           4'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
